guess_game_param: RTL
=====================

Name: guess_game_param

Overview:
- Parametrised successor of the number-guessing game top level.
- Combines three pieces in one sequential block:
  - a free-running secret counter of configurable width;
  - an edge-detected guess entry with a bounded attempt budget;
  - registered over/under/equal indicators plus win/lose flags.
- Drives the board LEDs and 7-seg status directly; sits under the board top, fed by debounced switch/button inputs.

Parameters:
- WIDTH, 8, bit width of guess and secret value; legal range 2..16.
- MAX_TRIES, 8, guesses allowed before loss; legal range 1..(2^TW - 1).
- TW, $clog2(MAX_TRIES+1), width of the tries counter (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enter  in  1  debounced guess button, level (high = pressed)
- guess  in  WIDTH  player's guess
- actual  out  WIDTH  secret value register
- dp_over  out  1  registered: last guess > actual
- dp_under  out  1  registered: last guess < actual
- dp_equal  out  1  registered: last guess == actual
- tries  out  TW  guesses consumed
- game_won  out  1  high in S_WON
- game_lost  out  1  high in S_LOST

Behaviour:
- Reset values:
  - state = S_GEN; actual = 0; tries = 0.
  - dp_over/dp_under/dp_equal = 0; game_won/game_lost = 0.
  - guess_q = 0; enter_q = 1, so a button held through reset release is not a press.
- Press detection:
  - press = enter & ~enter_q; enter_q <= enter every cycle.
  - A held button yields exactly one press.
- S_GEN:
  - Without press: actual <= actual + 1 each cycle, wrapping modulo 2^WIDTH.
  - On press: actual holds, guess_q <= guess, go to S_CHECK.
- S_CHECK (exactly 1 cycle):
  - dp_over/dp_under/dp_equal <= compare(guess_q, actual) (unsigned); tries <= tries + 1.
  - If equal, go to S_WON.
  - Else if tries + 1 == MAX_TRIES, go to S_LOST.
  - Else go to S_WAIT.
- S_WAIT:
  - actual holds.
  - On press: guess_q <= guess, go to S_CHECK.
  - Otherwise stay; LEDs hold their previous result.
- S_WON / S_LOST:
  - Terminal; game_won or game_lost is high.
  - Presses are ignored; all outputs hold.
- Latency:
  - Press sampled at edge N; S_CHECK occupies cycle N+1.
  - LEDs, tries and terminal flags are visible after edge N+1.
- Boundary conditions:
  - Correct guess on the final try: S_WON has priority over S_LOST.
  - tries never exceeds MAX_TRIES.
  - Guess changes after the press edge do not affect the pending comparison, because guess_q is used.
  - Reset asserted mid-game (any state) asynchronously restores all reset values; the game restarts in S_GEN.
- Exactly one of dp_over/dp_under/dp_equal is high after the first check; all three are 0 before it.
- State encoding is implementation choice; no illegal-state lockup (default branch returns to S_GEN).

Optional Feature:
- Macro: GUESS_RESTART_EN.
- Defined:
  - In S_WON or S_LOST, a press returns to S_GEN.
  - Same edge: tries = 0, all LEDs = 0, game_won/game_lost = 0.
  - actual is not cleared; it resumes incrementing from its held value next cycle.
- Undefined: S_WON and S_LOST are terminal until reset; presses ignored.

Test Plan (WIDTH=8, MAX_TRIES=4 unless stated):
- Release reset, enter low for 10 clocks -> actual = 10. Then press with guess=10 -> two edges later dp_equal=1, game_won=1, tries=1, actual stays 10.
- Release reset, 5 clocks, press with guess=200 -> dp_over=1, dp_under=0, tries=1, state S_WAIT. Next press with guess=1 -> dp_under=1, tries=2.
- Freeze actual=5; press guesses 9, 8, 7, 6 -> after 4th check game_lost=1, tries=4. Fifth press with guess=5 -> no change.
- Freeze actual=5; three wrong guesses, then guess=5 on the 4th press -> game_won=1, game_lost=0, tries=4.
- Freeze actual, then hold enter high for 20 cycles -> tries increments by exactly 1. Also: WIDTH=4, 17 idle clocks after reset -> actual = 1 (wrap).
- Reset asserted mid-S_WAIT -> all outputs 0 immediately, without waiting for a clock. With GUESS_RESTART_EN: from S_WON, a press -> game_won=0, tries=0, actual increments again.

Source files
------------

// File: rtl/guess_game_param.sv
// ============================================================================
// Module      : guess_game_param
// Description : Number-guessing game core: free-running secret counter,
//               edge-detected guess entry with a bounded attempt budget,
//               registered over/under/equal LEDs and win/lose flags.
//               Optional macro GUESS_RESTART_EN: a press in a terminal state
//               starts a new round.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module guess_game_param #(
    parameter int WIDTH     = 8,
    parameter int MAX_TRIES = 8,
    parameter int TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] actual,
    output logic             dp_over,
    output logic             dp_under,
    output logic             dp_equal,
    output logic [TW-1:0]    tries,
    output logic             game_won,
    output logic             game_lost
);

    typedef enum logic [2:0] {
        S_GEN   = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_WON   = 3'd3,
        S_LOST  = 3'd4
    } state_t;

    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] actual_q, actual_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic             over_q, over_d;
    logic             under_q, under_d;
    logic             equal_q, equal_d;
    logic             enter_q;
    logic             press;
    logic [TW-1:0]    tries_inc;

    assign press     = enter & ~enter_q;
    assign tries_inc = tries_q + 1'b1;

    // enter_q resets high so a button held through reset release is not a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_GEN;
            actual_q <= '0;
            guess_q  <= '0;
            tries_q  <= '0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            equal_q  <= 1'b0;
            enter_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            actual_q <= actual_d;
            guess_q  <= guess_d;
            tries_q  <= tries_d;
            over_q   <= over_d;
            under_q  <= under_d;
            equal_q  <= equal_d;
            enter_q  <= enter;
        end
    end

    always_comb begin
        state_d  = state_q;
        actual_d = actual_q;
        guess_d  = guess_q;
        tries_d  = tries_q;
        over_d   = over_q;
        under_d  = under_q;
        equal_d  = equal_q;
        case (state_q)
            S_GEN: begin
                if (press) begin
                    guess_d = guess;
                    state_d = S_CHECK;
                end else begin
                    actual_d = actual_q + 1'b1;
                end
            end
            S_CHECK: begin
                over_d  = (guess_q > actual_q);
                under_d = (guess_q < actual_q);
                equal_d = (guess_q == actual_q);
                tries_d = tries_inc;
                // a correct final guess wins rather than loses
                if (guess_q == actual_q) begin
                    state_d = S_WON;
                end else if (tries_inc == LAST_TRY) begin
                    state_d = S_LOST;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (press) begin
                    guess_d = guess;
                    state_d = S_CHECK;
                end
            end
            S_WON, S_LOST: begin
`ifdef GUESS_RESTART_EN
                // actual is kept; it resumes counting from its held value
                if (press) begin
                    state_d = S_GEN;
                    tries_d = '0;
                    over_d  = 1'b0;
                    under_d = 1'b0;
                    equal_d = 1'b0;
                end
`else
                state_d = state_q;
`endif
            end
            default: begin
                state_d = S_GEN;
            end
        endcase
    end

    assign actual    = actual_q;
    assign dp_over   = over_q;
    assign dp_under  = under_q;
    assign dp_equal  = equal_q;
    assign tries     = tries_q;
    assign game_won  = (state_q == S_WON);
    assign game_lost = (state_q == S_LOST);

endmodule

`default_nettype wire
